// File: rtl/nibble_pkg.sv
// Shared types and framing constants for the nibble deserializer slice.
package nibble_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/nibble_shift_reg.sv
// DATA_W-bit serial-in shift register; MSB_FIRST selects which end the first bit settles in.
module nibble_shift_reg #(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (shift_en) begin
      // Entering at the far end means the first bit received finishes at the near end.
      if (MSB_FIRST) q <= {q[DATA_W-2:0], din};
      else           q <= {din, q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/nibble_deserializer.sv
// Framed serial-to-parallel converter feeding a load-gated register (start 0, DATA_W bits, stop 1).
module nibble_deserializer #(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              sin_valid,
  output logic [DATA_W-1:0] d_out,
  output logic              load,
  output logic              frame_err,
  output logic              busy
);
  import nibble_pkg::*;

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DATA_W);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              shift_en;
  logic              capture;
  logic              load_nxt;
  logic              ferr_nxt;
  logic [DATA_W-1:0] sr_q;

  nibble_shift_reg #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_en(shift_en),
    .din     (sin),
    .q       (sr_q)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    capture   = 1'b0;
    load_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (sin_valid && sin == START_BIT) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (sin_valid) begin
          shift_en = 1'b1;
          if (cnt != CNT_MAX) cnt_nxt = cnt + CW'(1);
          if (cnt == CNT_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (sin_valid) begin
          state_nxt = IDLE;
          if (sin == STOP_BIT) begin
            capture  = 1'b1;
            load_nxt = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy is registered from the next state so it drops on the stop-bit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      d_out     <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      load      <= load_nxt;
      frame_err <= ferr_nxt;
      busy      <= (state_nxt != IDLE);
      if (capture) d_out <= sr_q;
    end
  end

endmodule

// File: tb/tb_nibble_deserializer.sv
// Directed bench for nibble_deserializer: LSB-first instance plus an MSB-first instance on the same stream.
module tb_nibble_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b1;
  logic       sin_valid = 1'b0;
  logic [3:0] d_out0, d_out1;
  logic       load0, load1, frame_err0, frame_err1, busy0, busy1;

  int passed = 0;
  int total = 0;
  int load_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (load0 === 1'b1) load_cnt++;

  nibble_deserializer #(.DATA_W(4), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .d_out(d_out0), .load(load0), .frame_err(frame_err0), .busy(busy0)
  );

  nibble_deserializer #(.DATA_W(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .d_out(d_out1), .load(load1), .frame_err(frame_err1), .busy(busy1)
  );

  task automatic drive(input logic b);
    sin = b;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #3;
    total++; if (d_out0 !== 4'h0) $display("FAIL reset_dout got %h exp 0", d_out0); else passed++;
    total++; if (load0 !== 1'b0) $display("FAIL reset_load got %b exp 0", load0); else passed++;
    total++; if (frame_err0 !== 1'b0) $display("FAIL reset_ferr got %b exp 0", frame_err0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy0); else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    logic [3:0] w;
    int base;
    w = 4'b1101;
    base = load_cnt;
    drive(1'b0);
    total++; if (busy0 !== 1'b1) $display("FAIL basic_busy_start got %b exp 1", busy0); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(w[i]);
      total++; if (busy0 !== 1'b1) $display("FAIL basic_busy_bit%0d got %b exp 1", i, busy0); else passed++;
    end
    drive(1'b1);
    total++; if (load0 !== 1'b1) $display("FAIL basic_load got %b exp 1", load0); else passed++;
    total++; if (d_out0 !== 4'b1101) $display("FAIL basic_dout got %h exp d", d_out0); else passed++;
    total++; if (frame_err0 !== 1'b0) $display("FAIL basic_ferr got %b exp 0", frame_err0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL basic_busy_end got %b exp 0", busy0); else passed++;
    idle(1);
    total++; if (load0 !== 1'b0) $display("FAIL basic_load_drop got %b exp 0", load0); else passed++;
    total++; if (load_cnt - base !== 1) $display("FAIL basic_load_count got %0d exp 1", load_cnt - base); else passed++;
  endtask

  task automatic test_gaps;
    logic [3:0] w;
    int base;
    w = 4'b1101;
    base = load_cnt;
    drive(1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(3);
      total++; if (busy0 !== 1'b1) $display("FAIL gap_busy_before_bit%0d got %b exp 1", i, busy0); else passed++;
      drive(w[i]);
    end
    idle(3);
    total++; if (busy0 !== 1'b1) $display("FAIL gap_busy_before_stop got %b exp 1", busy0); else passed++;
    total++; if (load0 !== 1'b0) $display("FAIL gap_load_early got %b exp 0", load0); else passed++;
    drive(1'b1);
    total++; if (load0 !== 1'b1) $display("FAIL gap_load got %b exp 1", load0); else passed++;
    idle(2);
    total++; if (d_out0 !== 4'b1101) $display("FAIL gap_dout got %h exp d", d_out0); else passed++;
    total++; if (load_cnt - base !== 1) $display("FAIL gap_load_count got %0d exp 1", load_cnt - base); else passed++;
  endtask

  task automatic test_frame_err;
    logic [3:0] w;
    w = 4'b1100;
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(w[i]);
    drive(1'b0);
    total++; if (frame_err0 !== 1'b1) $display("FAIL ferr_pulse got %b exp 1", frame_err0); else passed++;
    total++; if (load0 !== 1'b0) $display("FAIL ferr_load got %b exp 0", load0); else passed++;
    total++; if (d_out0 !== 4'b1101) $display("FAIL ferr_dout_hold got %h exp d", d_out0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL ferr_busy got %b exp 0", busy0); else passed++;
    idle(1);
    total++; if (frame_err0 !== 1'b0) $display("FAIL ferr_drop got %b exp 0", frame_err0); else passed++;
    w = 4'b1111;
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(w[i]);
    drive(1'b1);
    total++; if (load0 !== 1'b1) $display("FAIL ferr_next_load got %b exp 1", load0); else passed++;
    total++; if (d_out0 !== 4'b1111) $display("FAIL ferr_next_dout got %h exp f", d_out0); else passed++;
    idle(1);
  endtask

  task automatic test_back_to_back;
    logic [3:0] a, b;
    a = 4'h3;
    b = 4'hA;
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(a[i]);
    drive(1'b1);
    total++; if (load0 !== 1'b1) $display("FAIL b2b_load1 got %b exp 1", load0); else passed++;
    total++; if (d_out0 !== 4'h3) $display("FAIL b2b_dout1 got %h exp 3", d_out0); else passed++;
    drive(1'b0);
    total++; if (busy0 !== 1'b1) $display("FAIL b2b_start_busy got %b exp 1", busy0); else passed++;
    total++; if (load0 !== 1'b0) $display("FAIL b2b_load_gap_start got %b exp 0", load0); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(b[i]);
      total++; if (load0 !== 1'b0) $display("FAIL b2b_load_gap%0d got %b exp 0", i, load0); else passed++;
    end
    drive(1'b1);
    total++; if (load0 !== 1'b1) $display("FAIL b2b_load2 got %b exp 1", load0); else passed++;
    total++; if (d_out0 !== 4'hA) $display("FAIL b2b_dout2 got %h exp a", d_out0); else passed++;
    idle(4);
    total++; if (d_out0 !== 4'hA) $display("FAIL b2b_dout_hold got %h exp a", d_out0); else passed++;
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] w;
    int base;
    w = 4'h6;
    drive(1'b0);
    drive(w[0]);
    drive(w[1]);
    base = load_cnt;
    #2 rst_n = 1'b0;
    #1;
    total++; if (d_out0 !== 4'h0) $display("FAIL midrst_dout got %h exp 0", d_out0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy0); else passed++;
    total++; if (load0 !== 1'b0) $display("FAIL midrst_load got %b exp 0", load0); else passed++;
    #2 rst_n = 1'b1;
    idle(2);
    total++; if (load_cnt !== base) $display("FAIL midrst_no_load got %0d exp %0d", load_cnt, base); else passed++;
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(w[i]);
    drive(1'b1);
    total++; if (load0 !== 1'b1) $display("FAIL midrst_next_load got %b exp 1", load0); else passed++;
    total++; if (d_out0 !== 4'h6) $display("FAIL midrst_next_dout got %h exp 6", d_out0); else passed++;
    idle(1);
  endtask

  task automatic test_msb_first;
    logic [3:0] w;
    w = 4'b0001;
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(w[i]);
    drive(1'b1);
    total++; if (load1 !== 1'b1) $display("FAIL msb_load got %b exp 1", load1); else passed++;
    total++; if (d_out1 !== 4'b1000) $display("FAIL msb_dout got %h exp 8", d_out1); else passed++;
    total++; if (d_out0 !== 4'b0001) $display("FAIL msb_lsb_ref_dout got %h exp 1", d_out0); else passed++;
    total++; if (frame_err1 !== 1'b0) $display("FAIL msb_ferr got %b exp 0", frame_err1); else passed++;
    idle(1);
    total++; if (load1 !== 1'b0) $display("FAIL msb_load_drop got %b exp 0", load1); else passed++;
    total++; if (busy1 !== 1'b0) $display("FAIL msb_busy got %b exp 0", busy1); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_msb_first();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
